// File: rtl/random_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | random_pkg : shared FSM state type and default constants for the         |
// |              random_source_arbiter block.  Revision: 1.0                 |
// +--------------------------------------------------------------------------+
package random_pkg;

  localparam int C_DEF_WIDTH         = 32;
  localparam int C_DEF_REQUESTERS    = 4;
  localparam int C_DEF_WARMUP_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_RESEED  = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_IDLE    = 3'd2,
    ST_STEP    = 3'd3,
    ST_DELIVER = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/random_source_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | random_source_arbiter_if : requester, delivery and CA-source signals.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface random_source_arbiter_if
  import random_pkg::*;
#(
  parameter int Width      = C_DEF_WIDTH,
  parameter int Requesters = C_DEF_REQUESTERS
);

  logic [Requesters-1:0] req;
  logic                  reseed;
  logic [Width-1:0]      src_random;
  logic                  src_ce;
  logic                  src_rst;
  logic [Requesters-1:0] valid;
  logic [Width-1:0]      random;
  logic                  ready;

  modport master (
    output req, reseed, src_random,
    input  src_ce, src_rst, valid, random, ready
  );

  modport slave (
    input  req, reseed, src_random,
    output src_ce, src_rst, valid, random, ready
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, first set bit after         |
// |              last_grant, wrapping modulo Requesters.  Revision: 1.0      |
// +--------------------------------------------------------------------------+
module rr_arbiter
  import random_pkg::*;
#(
  parameter int Requesters = C_DEF_REQUESTERS,
  localparam int IW        = $clog2(Requesters)
) (
  input  logic [Requesters-1:0] req,
  input  logic [IW-1:0]         last_grant,
  output logic [IW-1:0]         winner,
  output logic                  any
);

  logic [IW:0] w_pos;

  // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    winner = '0;
    w_pos  = '0;
    for (int i = Requesters; i >= 1; i--) begin
      w_pos = {1'b0, last_grant} + (IW+1)'(i);
      if (w_pos >= (IW+1)'(Requesters)) begin
        w_pos = w_pos - (IW+1)'(Requesters);
      end
      if (req[w_pos[IW-1:0]]) begin
        winner = w_pos[IW-1:0];
      end
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/random_source_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | random_source_arbiter : shares one external CA random source among       |
// | round-robin requesters; each word is stepped once and delivered once.    |
// | Option: RANDOM_SOURCE_ARBITER_IDLE_RUN_EN keeps the source stepping in   |
// | IDLE.  Revision: 1.0                                                     |
// +--------------------------------------------------------------------------+
module random_source_arbiter
  import random_pkg::*;
#(
  parameter int Width        = C_DEF_WIDTH,
  parameter int Requesters   = C_DEF_REQUESTERS,
  parameter int WarmupCycles = C_DEF_WARMUP_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  random_source_arbiter_if.slave  bus
);

  localparam int IW = $clog2(Requesters);
  localparam int CW = $clog2(WarmupCycles + 1);

  localparam logic [CW-1:0] C_WARM_LOAD  = CW'(WarmupCycles - 1);
  localparam logic [IW-1:0] C_LAST_RESET = IW'(Requesters - 1);
  localparam logic [Requesters-1:0] C_ONE = {{(Requesters-1){1'b0}}, 1'b1};

  state_e                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_last_grant;
  logic [IW-1:0]         r_winner;
  logic [Requesters-1:0] r_valid;
  logic [Width-1:0]      r_random_hold;
  logic                  r_pending;

  logic [IW-1:0]         w_winner;
  logic                  w_any;
  logic                  w_step;

  rr_arbiter #(
    .Requesters (Requesters)
  ) u_rr_arbiter (
    .req        (bus.req),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .any        (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_WARMUP;
      r_cnt         <= C_WARM_LOAD;
      r_last_grant  <= C_LAST_RESET;
      r_winner      <= '0;
      r_valid       <= '0;
      r_random_hold <= '0;
      r_pending     <= 1'b0;
    end else begin
      r_valid <= '0;
      // Reseed requests outside IDLE are remembered; repeats collapse into one.
      if (bus.reseed && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_RESEED: begin
          r_cnt   <= C_WARM_LOAD;
          r_state <= ST_WARMUP;
        end
        ST_WARMUP: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.reseed || r_pending) begin
            r_pending <= 1'b0;
            r_state   <= ST_RESEED;
          end else if (w_any) begin
            r_winner <= w_winner;
            r_state  <= ST_STEP;
          end
        end
        ST_STEP: begin
          r_valid <= C_ONE << r_winner;
          r_state <= ST_DELIVER;
        end
        ST_DELIVER: begin
          r_random_hold <= bus.src_random;
          r_last_grant  <= r_winner;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RANDOM_SOURCE_ARBITER_IDLE_RUN_EN
  assign w_step = (r_state == ST_WARMUP) || (r_state == ST_STEP) || (r_state == ST_IDLE);
`else
  assign w_step = (r_state == ST_WARMUP) || (r_state == ST_STEP);
`endif

  assign bus.src_ce  = w_step && !rst;
  assign bus.src_rst = rst || (r_state == ST_RESEED);
  assign bus.valid   = r_valid;
  // The freshly stepped word is presented alongside valid and held afterwards.
  assign bus.random  = (r_state == ST_DELIVER) ? bus.src_random : r_random_hold;
  assign bus.ready   = (r_state == ST_IDLE) || (r_state == ST_STEP) || (r_state == ST_DELIVER);

endmodule

`default_nettype wire

// File: tb/tb_random_source_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_random_source_arbiter : directed self-checking bench with a small     |
// | xorshift model standing in for the CA source.  Revision: 1.0             |
// +--------------------------------------------------------------------------+
module tb_random_source_arbiter;
  import random_pkg::*;

  localparam logic [31:0] C_SEED = 32'hACE1_2345;
`ifdef RANDOM_SOURCE_ARBITER_IDLE_RUN_EN
  localparam int C_IDLE_CE = 10;
  localparam int C_RESEED_STEPS = 18;
`else
  localparam int C_IDLE_CE = 0;
  localparam int C_RESEED_STEPS = 17;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] r_src;
  int          steps;
  int          n_checks = 0;
  int          n_fail   = 0;

  random_source_arbiter_if #(.Width(32), .Requesters(4)) bus ();

  random_source_arbiter #(
    .Width        (32),
    .Requesters   (4),
    .WarmupCycles (16)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Stand-in for the external CA source: reset on src_rst, advance on src_ce.
  always @(posedge clk) begin
    if (bus.src_rst) begin
      r_src <= C_SEED;
      steps <= 0;
    end else if (bus.src_ce) begin
      r_src <= xs_next(r_src);
      steps <= steps + 1;
    end
  end

  assign bus.src_random = r_src;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ready;
    int srst_cnt;
    int ce_cnt;
    int vidx;
    logic [3:0]  exp_v;
    logic [3:0]  vval;
    logic [31:0] w;
    logic [31:0] vrand;
    logic [31:0] vsrc;
    int vsteps;

    bus.req    = '0;
    bus.reseed = 1'b0;
    rst        = 1'b1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_src_rst", 32'(bus.src_rst), 32'd1);
    check("rst_src_ce",  32'(bus.src_ce),  32'd0);
    check("rst_valid",   32'(bus.valid),   32'd0);
    check("rst_random",  bus.random,       32'd0);
    check("rst_ready",   32'(bus.ready),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Warm-up after reset: 16 source steps, ready on cycle 17
    first_ready = 0;
    srst_cnt    = 0;
    for (int i = 1; i <= 40 && first_ready == 0; i++) begin
      @(negedge clk);
      if (bus.src_rst) srst_cnt++;
      if (bus.ready) first_ready = i;
    end
    check("warm_ready_cycle", 32'(first_ready + 1), 32'd17);
    check("warm_steps",       32'(steps),           32'd16);
    check("warm_src_rst",     32'(srst_cnt),        32'd0);

    // Idle source activity for 10 cycles
    ce_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.src_ce) ce_cnt++;
    end
    check("idle_ce_count", 32'(ce_cnt), 32'(C_IDLE_CE));
    check("idle_ready",    32'(bus.ready), 32'd1);

    // All four requesting: 0001,0010,0100,1000,0001 every third cycle
    bus.req = 4'b1111;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      exp_v = ((i % 3) == 2) ? (4'b0001 << ((i / 3) % 4)) : 4'b0000;
      check($sformatf("rr_valid_%0d", i), 32'(bus.valid), 32'(exp_v));
      if (exp_v != 4'b0000) begin
        check($sformatf("rr_random_%0d", i), bus.random, r_src);
      end
      if (i == 14) bus.req = 4'b0000;
    end

    // Lone requester 2: src_ce at T+1, valid at T+2
    @(negedge clk);
    bus.req = 4'b0100;
    @(negedge clk);
    check("lat_ce_t1",    32'(bus.src_ce), 32'd1);
    check("lat_valid_t1", 32'(bus.valid),  32'd0);
    @(negedge clk);
    check("lat_valid_t2",  32'(bus.valid), 32'h4);
    check("lat_random_t2", bus.random,     r_src);
    w = r_src;
    bus.req = 4'b0000;
    @(negedge clk);
    check("lat_valid_t3", 32'(bus.valid), 32'd0);
    check("lat_hold",     bus.random,     w);

    // Same lone requester again right after its own grant
    bus.req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check("single_again", 32'(bus.valid), 32'h4);
    bus.req = 4'b0000;
    @(negedge clk);

    // Reseed and request together in IDLE: reseed first, then requester 0
    bus.reseed = 1'b1;
    bus.req    = 4'b0001;
    srst_cnt = 0;
    vidx     = 0;
    vval     = '0;
    vrand    = '0;
    vsrc     = '1;
    vsteps   = 0;
    for (int i = 1; i <= 40 && vidx == 0; i++) begin
      @(negedge clk);
      if (bus.src_rst) srst_cnt++;
      if (bus.valid != 4'b0000) begin
        vidx   = i;
        vval   = bus.valid;
        vrand  = bus.random;
        vsrc   = r_src;
        vsteps = steps;
      end
      bus.reseed = 1'b0;
    end
    bus.req = 4'b0000;
    check("rsd_src_rst_cycles", 32'(srst_cnt), 32'd1);
    check("rsd_valid_cycle",    32'(vidx),     32'd20);
    check("rsd_valid",          32'(vval),     32'h1);
    check("rsd_steps",          32'(vsteps),   32'(C_RESEED_STEPS));
    check("rsd_random",         vrand,         vsrc);

    // Two reseed pulses during STEP/DELIVER collapse into one RESEED
    @(negedge clk);
    bus.req = 4'b0010;
    @(negedge clk);
    bus.reseed = 1'b1;
    @(negedge clk);
    check("dbl_valid", 32'(bus.valid), 32'h2);
    bus.req = 4'b0000;
    @(negedge clk);
    bus.reseed = 1'b0;
    srst_cnt = 0;
    ce_cnt   = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.src_rst) srst_cnt++;
      if (bus.valid != 4'b0000) ce_cnt++;
    end
    check("dbl_reseed_count", 32'(srst_cnt), 32'd1);
    check("dbl_no_valid",     32'(ce_cnt),   32'd0);
    check("dbl_ready",        32'(bus.ready), 32'd1);

    // Reset during a pending delivery drops the valid pulse
    bus.req = 4'b1000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_valid",   32'(bus.valid),   32'd0);
    check("rstmid_src_rst", 32'(bus.src_rst), 32'd1);
    check("rstmid_src_ce",  32'(bus.src_ce),  32'd0);
    check("rstmid_random",  bus.random,       32'd0);
    rst     = 1'b0;
    bus.req = 4'b0000;
    first_ready = 0;
    ce_cnt      = 0;
    for (int i = 1; i <= 40 && first_ready == 0; i++) begin
      @(negedge clk);
      if (bus.valid != 4'b0000) ce_cnt++;
      if (bus.ready) first_ready = i;
    end
    check("rstmid_no_valid", 32'(ce_cnt),      32'd0);
    check("rstmid_ready",    32'(first_ready), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/random_source_arbiter.md
RANDOM_SOURCE_ARBITER -- requirements
Module: random_source_arbiter

Interface
REQ-001 SHALL have parameter Width, default 32, meaning the random word width in bits.
REQ-002 SHALL have parameter Requesters, default 4, meaning the number of requesters (2..16).
REQ-003 SHALL have parameter WarmupCycles, default 16, meaning the number of source steps after reset/reseed before service (>=1).
REQ-004 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port req  input  Requesters  per-requester word request; held high until its valid bit.
REQ-007 SHALL have port reseed  input  1  one-cycle pulse requesting source reset plus warm-up.
REQ-008 SHALL have port src_random  input  Width  current state word of the external CA random source.
REQ-009 SHALL have port src_ce  output  1  step-enable to the source.
REQ-010 SHALL have port src_rst  output  1  reset to the source.
REQ-011 SHALL have port valid  output  Requesters  one-hot, one-cycle delivery strobe.
REQ-012 SHALL have port random  output  Width  delivered word; registered, held between deliveries.
REQ-013 SHALL have port ready  output  1  high when the state is IDLE, STEP or DELIVER.

Function
REQ-014 SHALL implement FSM states RESEED, WARMUP, IDLE, STEP, DELIVER.
REQ-015 In RESEED, SHALL assert src_rst for exactly one cycle, load warm-up counter with WarmupCycles-1, then go to WARMUP.
REQ-016 In WARMUP, SHALL assert src_ce every cycle and decrement the counter; at counter==0, SHALL go to IDLE after that cycle, giving exactly WarmupCycles steps.
REQ-017 In IDLE with reseed (pulse this cycle or latched pending), SHALL go to RESEED and clear the pending flag; reseed SHALL win over simultaneous req.
REQ-018 In IDLE with any req bit and no reseed, SHALL register the round-robin winner: first set bit searching from last_grant+1 upward, wrapping modulo Requesters; then go to STEP.
REQ-019 In STEP, SHALL assert src_ce for exactly one cycle, then go to DELIVER.
REQ-020 In DELIVER, SHALL sample src_random into random, pulse valid[winner] for one cycle, set last_grant=winner, then go to IDLE.
REQ-021 Request-to-valid latency from IDLE SHALL be 2 cycles; maximum throughput SHALL be one word per 3 cycles; no word SHALL ever be delivered twice.
REQ-022 A req dropped after being registered SHALL still receive its valid pulse; the word SHALL be consumed.
REQ-023 A reseed pulse arriving outside IDLE SHALL be latched and serviced at the next IDLE; multiple pulses SHALL collapse into one.
REQ-024 With a single active requester, SHALL grant it on every IDLE pass regardless of last_grant.

Reset
REQ-025 rst SHALL force state WARMUP with counter WarmupCycles-1, last_grant Requesters-1 (requester 0 first), valid 0, random 0, reseed pending 0.
REQ-026 src_rst SHALL equal rst OR (state==RESEED); src_ce SHALL be 0 while rst is high.
REQ-027 rst mid-delivery SHALL suppress the pending valid pulse.

Configuration
REQ-028 With RANDOM_SOURCE_ARBITER_IDLE_RUN_EN defined, SHALL also assert src_ce in every IDLE cycle (free-running source).
REQ-029 Without RANDOM_SOURCE_ARBITER_IDLE_RUN_EN, src_ce SHALL be high only in WARMUP and STEP.

Structure
REQ-030 SHALL place the FSM state typedef (3-bit enum) and default parameter constants in the shared package random_pkg.
REQ-031 SHALL implement winner selection in one sub-module, rr_arbiter (req, last_grant in; winner index, any out; combinational).
REQ-032 SHALL NOT instantiate the CA source; it connects via src_* ports.

Verification
REQ-033 Reset, WarmupCycles=16, no req -> src_ce high exactly 16 cycles; ready rises on cycle 17; src_rst high only during rst.
REQ-034 req=4'b1111 held -> valid sequence 0001,0010,0100,1000,0001, one pulse every 3 cycles.
REQ-035 req=4'b0100 alone in IDLE at cycle T -> src_ce at T+1, valid=4'b0100 at T+2, random equals src_random sampled at T+2.
REQ-036 reseed and req=4'b0001 in same IDLE cycle -> src_rst 1 cycle, 16 warm-up steps, then requester 0 served.
REQ-037 reseed pulsed twice during STEP/DELIVER -> exactly one RESEED after DELIVER.
REQ-038 IDLE_RUN_EN defined, no req for 10 cycles -> src_ce high all 10; undefined -> src_ce low all 10.
